// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data, flush,
// downstream valid/ready/data and the back-pressure counter.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 39,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 39,
    parameter int CNT_W  = 8
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              out_valid_c;
    logic              in_ready_c;
    logic              in_fire;
    logic              out_fire;
    logic [DATA_W-1:0] head_q;
    logic [CNT_W-1:0]  stall_q;

    assign in_fire  = bus.in_valid && in_ready_c && !bus.flush;
    assign out_fire = out_valid_c && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;

    // ready_q resets high so in_ready rises as soon as rst is released
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_d = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_d = TWO;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                TWO:     if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid_c = (state_q != EMPTY);
        in_ready_c  = ready_q && rst;
    end

    // head_q is always the oldest entry; skid_q only holds the second one
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else if (!bus.flush) begin
            case (state_q)
                EMPTY: if (in_fire) head_q <= bus.in_data;
                ONE: begin
                    if (in_fire && out_fire) head_q <= bus.in_data;
                    else if (in_fire)        skid_q <= bus.in_data;
                end
                TWO:     if (out_fire) head_q <= skid_q;
                default: ;
            endcase
        end
    end
`else
    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush)                                       state_d = EMPTY;
        else if (state_q == EMPTY && in_fire)                state_d = FULL;
        else if (state_q == FULL && out_fire && !in_fire)    state_d = EMPTY;
    end

    always_comb begin
        out_valid_c = (state_q == FULL);
        in_ready_c  = rst && (!out_valid_c || bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst)         head_q <= '0;
        else if (in_fire) head_q <= bus.in_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            stall_q <= '0;
        else if (out_valid_c && !bus.out_ready && !bus.flush && stall_q != CNT_MAX)
            stall_q <= stall_q + 1'b1;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = head_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model,
// a streaming vector table and hand-written corner sequences.
module tb_pipe_stage_reg;
    localparam int DATA_W = 39;
    localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic              iv;
        logic [DATA_W-1:0] d;
        logic              ordy;
        logic              fl;
        logic              ev;
        logic [DATA_W-1:0] ed;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                compared   = 0;
    int                mismatched = 0;
    logic [DATA_W-1:0] sb_q[$];
    int                stall_model = 0;
    bit                live = 1'b0;
    bit                in_fire_m, out_fire_m, stall_inc_m, rs_m, fl_m;
    logic [DATA_W-1:0] d_m;
    vec_t              tab[7];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and check outputs against the model
    task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                                 input logic fl, input logic rs);
        logic exp_rdy;
        int   n;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = rs;
        #1;
        n       = sb_q.size();
        exp_rdy = rs && (SKID ? (n < 2) : (n == 0 || ordy));
        checkOutput("in_ready", bus.in_ready, exp_rdy);
        if (live) begin
            checkOutput("out_valid", bus.out_valid, n != 0);
            checkOutput("stall_cnt", bus.stall_cnt, stall_model);
            if (n != 0)
                checkOutput((rs && ordy && !fl) ? "sb_pop" : "held_data", bus.out_data, sb_q[0]);
        end
        in_fire_m   = rs && iv && exp_rdy && !fl;
        out_fire_m  = rs && !fl && n != 0 && ordy;
        stall_inc_m = rs && !fl && n != 0 && !ordy;
        rs_m        = rs;
        fl_m        = fl;
        d_m         = d;
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rs_m) begin
            sb_q.delete();
            stall_model = 0;
            live        = 1'b1;
        end else if (fl_m) begin
            sb_q.delete();
        end else begin
            if (out_fire_m) void'(sb_q.pop_front());
            if (in_fire_m)  sb_q.push_back(d_m);
            if (stall_inc_m && stall_model < (1 << CNT_W) - 1) stall_model++;
        end
    endtask

    task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                         input logic fl, input logic rs);
        applyStimulus(iv, d, ordy, fl, rs);
        advance();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        tab[0] = '{1'b1, 39'd1, 1'b1, 1'b0, 1'b0, 39'd0};
        tab[1] = '{1'b1, 39'd2, 1'b1, 1'b0, 1'b1, 39'd1};
        tab[2] = '{1'b1, 39'd3, 1'b1, 1'b0, 1'b1, 39'd2};
        tab[3] = '{1'b1, 39'd4, 1'b1, 1'b0, 1'b1, 39'd3};
        tab[4] = '{1'b1, 39'd5, 1'b1, 1'b0, 1'b1, 39'd4};
        tab[5] = '{1'b0, 39'd0, 1'b1, 1'b0, 1'b1, 39'd5};
        tab[6] = '{1'b0, 39'd0, 1'b1, 1'b0, 1'b0, 39'd0};

        // Reset held for two cycles with a payload offered
        cycle(1'b1, 39'h1A5, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 39'h1A5, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("reset_valid", bus.out_valid, 1'b0);
        checkOutput("reset_data", bus.out_data, '0);
        checkOutput("reset_stall", bus.stall_cnt, '0);
        checkOutput("reset_ready", bus.in_ready, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Streaming table
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tab[i].iv, tab[i].d, tab[i].ordy, tab[i].fl, 1'b1);
            checkOutput("tab_valid", bus.out_valid, tab[i].ev);
            if (tab[i].ev) checkOutput("tab_data", bus.out_data, tab[i].ed);
            advance();
        end

        // Back-pressure: 7 held for three cycles while 8 is offered
        cycle(1'b1, 39'd7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 39'd8, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 39'd8, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_hold", bus.out_data, 39'd7);
        checkOutput("bp_stall", bus.stall_cnt, 4'd3);
`ifdef PIPE_STAGE_SKID_EN
        checkOutput("bp_skid_full", bus.in_ready, 1'b0);
`endif
        advance();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_second", bus.out_data, 39'd8);
        checkOutput("bp_second_valid", bus.out_valid, 1'b1);
        advance();

        // Flush with entries held and 9 offered
        cycle(1'b1, 39'd10, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 39'd11, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 39'd9, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_valid", bus.out_valid, 1'b0);
        checkOutput("flush_stall", bus.stall_cnt, 4'd4);
        advance();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Saturation of the 4-bit counter
        cycle(1'b1, 39'h55, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("stall_sat", bus.stall_cnt, 4'd15);
        advance();

        // Reset mid-stream with the stage full
        cycle(1'b1, 39'h21, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 39'h22, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 39'h23, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("midrst_valid", bus.out_valid, 1'b0);
        checkOutput("midrst_data", bus.out_data, '0);
        checkOutput("midrst_stall", bus.stall_cnt, '0);
        cycle(1'b1, 39'h24, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  DATA_W'({$urandom(), $urandom()}),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 59) != 0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
